// File: rtl/huffman_encoder.sv
// Serializing Huffman encoder: 5-bit symbols in through a small FIFO, prefix codes out MSB first.
// Optional macro HUFFMAN_ENC_ERR_EN drives err for illegal symbols; otherwise err is tied low.
module huffman_encoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sym_valid,
  input  logic [4:0] sym,
  output logic       sym_ready,
  output logic       bit_out,
  output logic       bit_valid,
  input  logic       bit_ready,
  output logic       bit_last,
  output logic       busy,
  output logic       err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  logic [4:0]    fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  state_t        state_r;
  state_t        state_nxt_s;
  logic [7:0]    shift_r;
  logic [3:0]    cnt_r;
  logic          push_s;
  logic          pop_s;
  logic          load_s;
  logic          adv_s;
  logic          full_s;
  logic          empty_s;
  logic          head_legal_s;
  logic [11:0]   entry_s;

  // Returns {length, code left-aligned in 8 bits}; length 0 marks an illegal symbol.
  function automatic logic [11:0] code_lookup(input logic [4:0] s);
    case (s)
      5'd1:    code_lookup = {4'd2, 8'b0000_0000};
      5'd2:    code_lookup = {4'd2, 8'b0100_0000};
      5'd3:    code_lookup = {4'd2, 8'b1000_0000};
      5'd4:    code_lookup = {4'd3, 8'b1100_0000};
      5'd5:    code_lookup = {4'd6, 8'b1110_0000};
      5'd6:    code_lookup = {4'd6, 8'b1110_0100};
      5'd7:    code_lookup = {4'd6, 8'b1110_1000};
      5'd8:    code_lookup = {4'd7, 8'b1110_1100};
      5'd9:    code_lookup = {4'd7, 8'b1110_1110};
      5'd10:   code_lookup = {4'd7, 8'b1111_0000};
      5'd11:   code_lookup = {4'd7, 8'b1111_0010};
      5'd12:   code_lookup = {4'd7, 8'b1111_0100};
      5'd13:   code_lookup = {4'd7, 8'b1111_0110};
      5'd14:   code_lookup = {4'd7, 8'b1111_1000};
      5'd15:   code_lookup = {4'd7, 8'b1111_1010};
      5'd16:   code_lookup = {4'd7, 8'b1111_1100};
      5'd17:   code_lookup = {4'd8, 8'b1111_1110};
      5'd18:   code_lookup = {4'd8, 8'b1111_1111};
      default: code_lookup = {4'd0, 8'b0000_0000};
    endcase
  endfunction

  assign full_s       = (count_r == FULL_CNT);
  assign empty_s      = (count_r == '0);
  assign sym_ready    = !full_s;
  assign push_s       = sym_valid && !full_s;
  assign entry_s      = code_lookup(fifo_mem_r[rd_ptr_r]);
  assign head_legal_s = (entry_s[11:8] != 4'd0);

  // FIFO storage; no reset needed since reads are qualified by count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= sym;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next state and pop/load/shift strobes. An illegal head reached at the end
  // of a code is left for IDLE to discard, so err never depends on bit_ready.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    load_s      = 1'b0;
    adv_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s = 1'b1;
          if (head_legal_s) begin
            load_s      = 1'b1;
            state_nxt_s = SHIFT;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (bit_ready) begin
          if (cnt_r == 4'd1 && !empty_s && head_legal_s) begin
            pop_s  = 1'b1;
            load_s = 1'b1;
          end else if (cnt_r == 4'd1) begin
            adv_s       = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            adv_s = 1'b1;
          end
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Code shifter and remaining-bit counter; a full drain leaves the shifter at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_r <= 8'd0;
      cnt_r   <= 4'd0;
    end else if (load_s) begin
      shift_r <= entry_s[7:0];
      cnt_r   <= entry_s[11:8];
    end else if (adv_s) begin
      shift_r <= {shift_r[6:0], 1'b0};
      cnt_r   <= cnt_r - 4'd1;
    end else begin
      shift_r <= shift_r;
      cnt_r   <= cnt_r;
    end
  end

  assign bit_valid = (state_r == SHIFT);
  assign bit_out   = shift_r[7];
  assign bit_last  = bit_valid && (cnt_r == 4'd1);
  assign busy      = !empty_s || bit_valid;

`ifdef HUFFMAN_ENC_ERR_EN
  assign err = (state_r == IDLE) && !empty_s && !head_legal_s;
`else
  assign err = 1'b0;
`endif

endmodule
